accl_pair_sched: RTL and testbench
==================================

# accl_pair_sched

Pair sequencer directly upstream of `getAccl`. On `start`, it walks every ordered body pair (i, j) of an N-body set held in the body RAM, one pair per clock. For each pair it drives `x1/y1` (body i), `x2/y2/m2` (body j) into `getAccl`. It also carries a tag (`i`, last-of-row) through a delay line so the tag emerges aligned with the `ax/ay` results for the downstream accumulator.

## Interface
- `MAX_BODIES`, default 64: body RAM depth; `AW = $clog2(MAX_BODIES)`.
- `ACCL_LATENCY`, default 123: `getAccl` input-to-`ax/ay` latency in cycles. Default is 1 + AddTime + MultTime + AddTime + InvSqrtTime + 4·MultTime at 11/20/27.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `n_bodies` in AW+1: body count; sampled with `start`.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse after the last tagged result.
- `rd_en` out 1: RAM read strobe.
- `rd_addr_i`, `rd_addr_j` out AW: RAM read addresses; the RAM has a synchronous 1-cycle read.
- `xi`, `yi`, `xj`, `yj`, `mj` in 64 each: RAM read data (IEEE-754 double; `mj` is pre-multiplied by G).
- `x1`, `y1`, `x2`, `y2`, `m2` out 64 each: registered operands to `getAccl`.
- `pair_valid` out 1: the operands hold a real pair this cycle.
- `out_valid` out 1: `getAccl` `ax/ay` are valid this cycle.
- `out_i` out AW: index of the body receiving the `ax/ay` currently on the output.
- `out_last` out 1: this result is the final j for `out_i`.

## Operation
- FSM has three states: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `start`=1 with `n_eff`≥1 → ISSUE, i=j=0. `n_eff` = min(`n_bodies`, `MAX_BODIES`).
  - `start`=1 with `n_eff`=0 → `done` pulses next cycle; stay in IDLE; no reads.
- **ISSUE**
  - Each cycle: `rd_en`=1, `rd_addr_i`=i, `rd_addr_j`=j.
  - j increments each cycle. When j=`n_eff`−1, j←0 and i increments.
  - After issuing (`n_eff`−1, `n_eff`−1) → DRAIN.
  - Pair order is row-major: (0,0), (0,1), …, (0,N−1), (1,0), …
- **DRAIN**
  - No reads.
  - When the tag pipeline is empty (the last `out_valid` has been emitted) → assert `done` for one cycle and return to IDLE.
- Self-pairs (i=j) are issued unmodified; `getAccl` zeroes them internally.
- Operand stage (cycle after RAM data returns):
  - Register `xi`, `yi`, `xj`, `yj`, `mj` onto `x1`, `y1`, `x2`, `y2`, `m2`.
  - `pair_valid`=1.
  - On non-valid cycles: `m2`←0; `x1/y1/x2/y2` hold their last values.
- Tag {valid, i, j==`n_eff`−1} enters the delay line with `pair_valid` and exits after exactly `ACCL_LATENCY` cycles as {`out_valid`, `out_i`, `out_last`}.
- `start` while `busy` is ignored. `n_bodies` changes mid-run are ignored because the value is latched.
- Reset is asserted asynchronously and released synchronously to `clk` externally. It is legal at any time, including mid-run: the FSM goes to IDLE, counters clear, and the tag pipeline flushes so no stale `out_valid` appears.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled; N = `n_eff`, L = `ACCL_LATENCY`.
- Issue (`rd_en`): cycles 1 … N².
- `pair_valid`: cycles 3 … N²+2.
- `out_valid`: cycles 3+L … N²+2+L.
- `done`: cycle N²+3+L.
- `busy`: 1 during cycles 1 … N²+2+L; 0 in the `done` cycle.
- Throughput is 1 pair/cycle with no bubbles inside a run.
- Back-to-back runs: a `start` in the `done` cycle is accepted (FSM already in IDLE).
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr_i`=0, `rd_addr_j`=0, `x1`=`y1`=`x2`=`y2`=`m2`=0, `pair_valid`=0, `out_valid`=0, `out_i`=0, `out_last`=0.

## Structure
- Shared package `nbody_pkg` contains:
  - `FP_W`=64.
  - `MULT_TIME`=11, `ADD_TIME`=20, `INVSQRT_TIME`=27.
  - `ACCL_LATENCY` derived from the timing constants.
  - Typedef `pair_tag_t` {valid, idx, last}.
  - Enum `sched_state_e` {IDLE, ISSUE, DRAIN}.
- One sub-module: `pair_tag_delay`, a parameterised-depth, reset-flushed shift register of `pair_tag_t`.
- DRAIN exit condition: counter of in-flight tags, or a DRAIN down-counter loaded with L+2.

## Test plan
- N=1, L=123: single pair (0,0).
  - `pair_valid` at cycle 3 with `x1`=`x2`.
  - `out_valid` at cycle 126 with `out_i`=0, `out_last`=1.
  - `done` at cycle 127.
- N=3, RAM x=k+1.0, y=2k+1.0, m=10k+1.0:
  - 9 pairs in row-major order.
  - `out_last` exactly at the j=2 results.
  - `out_i` sequence 0,0,0,1,1,1,2,2,2.
  - `done` at cycle 135.
- `n_bodies`=0: `done` at cycle 1; `rd_en`, `pair_valid`, `out_valid` never asserted.
- `start` pulsed again at cycle 50 of an N=4 run: ignored; exactly 16 `out_valid`; one `done`.
- `rst_n` low at cycle 10 of an N=4 run: all outputs reach reset values immediately. After release, no `out_valid` for 200 cycles; a new N=2 start completes normally.
- `n_bodies`=100 with `MAX_BODIES`=64: clamped to 64; 4096 pairs; `rd_addr` never exceeds 63.

Source files
------------

// File: rtl/nbody_pkg.sv
// Shared constants and types for the N-body acceleration pipeline.
package nbody_pkg;

  localparam int FP_W         = 64;
  localparam int MULT_TIME    = 11;
  localparam int ADD_TIME     = 20;
  localparam int INVSQRT_TIME = 27;

  // getAccl input-to-result latency: operand register, dx/dy subtract,
  // squaring, sum, inverse sqrt, then four chained multiplies.
  localparam int ACCL_LATENCY = 1 + ADD_TIME + MULT_TIME + ADD_TIME
                                + INVSQRT_TIME + 4 * MULT_TIME;

  localparam int MAX_BODIES_DEF = 64;
  localparam int IDX_W          = $clog2(MAX_BODIES_DEF);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             last;
  } pair_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pair_tag_delay.sv
// Fixed-depth shift register carrying pair tags alongside getAccl.
// Every stage is reset so a mid-run reset leaves no stale valid tag.
module pair_tag_delay
  import nbody_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  pair_tag_t tag_in,
  output pair_tag_t tag_out
);

  pair_tag_t pipe_q [DEPTH];
  pair_tag_t pipe_d [DEPTH];

  // Next-state: stage 0 takes the new tag, the rest shift by one.
  always_comb begin
    pipe_d[0] = tag_in;
    for (int k = 1; k < DEPTH; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  // Shift-register state with flush on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/accl_pair_sched.sv
// Walks all ordered body pairs (i, j) one per clock, feeds getAccl
// operands, and delays an {i, last-of-row} tag to line up with ax/ay.
module accl_pair_sched #(
  parameter  int MAX_BODIES   = 64,
  parameter  int ACCL_LATENCY = nbody_pkg::ACCL_LATENCY,
  localparam int AW           = $clog2(MAX_BODIES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [AW:0]                n_bodies,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [AW-1:0]              rd_addr_i,
  output logic [AW-1:0]              rd_addr_j,
  input  logic [nbody_pkg::FP_W-1:0] xi,
  input  logic [nbody_pkg::FP_W-1:0] yi,
  input  logic [nbody_pkg::FP_W-1:0] xj,
  input  logic [nbody_pkg::FP_W-1:0] yj,
  input  logic [nbody_pkg::FP_W-1:0] mj,
  output logic [nbody_pkg::FP_W-1:0] x1,
  output logic [nbody_pkg::FP_W-1:0] y1,
  output logic [nbody_pkg::FP_W-1:0] x2,
  output logic [nbody_pkg::FP_W-1:0] y2,
  output logic [nbody_pkg::FP_W-1:0] m2,
  output logic                       pair_valid,
  output logic                       out_valid,
  output logic [AW-1:0]              out_i,
  output logic                       out_last
);

  import nbody_pkg::*;

  localparam logic [AW:0] MAX_N = (AW+1)'(MAX_BODIES);
  // DRAIN covers two operand-pipeline stages plus the getAccl latency.
  localparam int          DW         = $clog2(ACCL_LATENCY + 2) + 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(ACCL_LATENCY + 1);

  sched_state_e  state_q, state_d;
  logic [AW:0]   n_q, n_d, n_eff_s;
  logic [AW-1:0] i_q, i_d, j_q, j_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
  logic          col_last_s, row_last_s;

  logic          s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [AW-1:0] s1_idx_q, s1_idx_d;

  logic [FP_W-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d, m2_q, m2_d;
  logic            pair_valid_q, pair_valid_d;
  pair_tag_t       tag_q, tag_d, tag_out_s;

  // Clamp the requested body count to the RAM depth.
  always_comb begin
    if (n_bodies > MAX_N) begin
      n_eff_s = MAX_N;
    end else begin
      n_eff_s = n_bodies;
    end
  end

  assign col_last_s = ({1'b0, j_q} == (n_q - (AW+1)'(1)));
  assign row_last_s = ({1'b0, i_q} == (n_q - (AW+1)'(1)));

  // Sequencer next-state: row-major pair walk, then drain until the tags exit.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    drain_d = drain_q;
    rd_en_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_eff_s != (AW+1)'(0)) begin
            state_d = ISSUE;
            n_d     = n_eff_s;
            i_d     = '0;
            j_d     = '0;
            rd_en_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ISSUE: begin
        if (col_last_s) begin
          j_d = '0;
          if (row_last_s) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
            i_d     = '0;
          end else begin
            i_d     = i_q + AW'(1);
            rd_en_d = 1'b1;
          end
        end else begin
          j_d     = j_q + AW'(1);
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(0)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Operand path: tag stage aligned with RAM data, then the operand register.
  always_comb begin
    s1_valid_d   = rd_en_q;
    pair_valid_d = s1_valid_q;
    x1_d = x1_q;
    y1_d = y1_q;
    x2_d = x2_q;
    y2_d = y2_q;
    if (rd_en_q) begin
      s1_idx_d  = i_q;
      s1_last_d = col_last_s;
    end else begin
      s1_idx_d  = '0;
      s1_last_d = 1'b0;
    end
    if (s1_valid_q) begin
      x1_d = xi;
      y1_d = yi;
      x2_d = xj;
      y2_d = yj;
      m2_d = mj;
    end else begin
      // Zero mass makes any stray operand contribute nothing.
      m2_d = '0;
    end
    tag_d.valid = s1_valid_q;
    tag_d.idx   = IDX_W'(s1_idx_q);
    tag_d.last  = s1_last_q;
  end

  // All sequencer and operand state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      drain_q      <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      s1_last_q    <= 1'b0;
      x1_q         <= '0;
      y1_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      m2_q         <= '0;
      pair_valid_q <= 1'b0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      i_q          <= i_d;
      j_q          <= j_d;
      drain_q      <= drain_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      s1_last_q    <= s1_last_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      m2_q         <= m2_d;
      pair_valid_q <= pair_valid_d;
      tag_q        <= tag_d;
    end
  end

  pair_tag_delay #(
    .DEPTH (ACCL_LATENCY)
  ) u_tag_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_q),
    .tag_out (tag_out_s)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr_i  = i_q;
  assign rd_addr_j  = j_q;
  assign x1         = x1_q;
  assign y1         = y1_q;
  assign x2         = x2_q;
  assign y2         = y2_q;
  assign m2         = m2_q;
  assign pair_valid = pair_valid_q;
  assign out_valid  = tag_out_s.valid;
  assign out_i      = AW'(tag_out_s.idx);
  assign out_last   = tag_out_s.last;

endmodule

// File: tb/tb_accl_pair_sched.sv
// Directed bench for accl_pair_sched with a synchronous-read body RAM model.
module tb_accl_pair_sched;

  localparam int AW = 6;
  localparam int L  = 123;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   n_bodies = '0;
  logic          busy, done, rd_en, pair_valid, out_valid, out_last;
  logic [AW-1:0] rd_addr_i, rd_addr_j, out_i;
  logic [63:0]   xi = '0, yi = '0, xj = '0, yj = '0, mj = '0;
  logic [63:0]   x1, y1, x2, y2, m2;

  logic [63:0] ram_x [64];
  logic [63:0] ram_y [64];
  logic [63:0] ram_m [64];

  accl_pair_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_bodies(n_bodies),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j),
    .xi(xi), .yi(yi), .xj(xj), .yj(yj), .mj(mj),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .m2(m2),
    .pair_valid(pair_valid), .out_valid(out_valid),
    .out_i(out_i), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Body RAM: one-cycle synchronous read.
  always @(posedge clk) begin
    if (rd_en) begin
      xi <= ram_x[rd_addr_i];
      yi <= ram_y[rd_addr_i];
      xj <= ram_x[rd_addr_j];
      yj <= ram_y[rd_addr_j];
      mj <= ram_m[rd_addr_j];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int start_cyc = 0;
  int exp_n = 0;
  int pv_cnt, pv_first, ov_cnt, ov_first, ov_lastc, last_cnt;
  int done_cnt, done_cyc, rd_cnt, max_addr, busy_cnt, busy_at_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_mon();
    pv_cnt = 0; pv_first = -1; ov_cnt = 0; ov_first = -1; ov_lastc = -1;
    last_cnt = 0; done_cnt = 0; done_cyc = -1; rd_cnt = 0; max_addr = 0;
    busy_cnt = 0; busy_at_done = -1;
  endtask

  // Monitor: samples on the falling edge, checks operand and tag order.
  always @(negedge clk) begin
    int rel, pi, pj, oc;
    if (rst_n) begin
      rel = cyc - start_cyc;
      if (rd_en) begin
        rd_cnt++;
        if (int'(rd_addr_i) > max_addr) max_addr = int'(rd_addr_i);
        if (int'(rd_addr_j) > max_addr) max_addr = int'(rd_addr_j);
      end
      if (busy) busy_cnt++;
      if (pair_valid) begin
        if (pv_first < 0) pv_first = rel;
        if (exp_n > 0) begin
          pi = pv_cnt / exp_n;
          pj = pv_cnt % exp_n;
          check_eq("x1", x1, $realtobits(real'(pi) + 1.0));
          check_eq("y1", y1, $realtobits(2.0 * real'(pi) + 1.0));
          check_eq("x2", x2, $realtobits(real'(pj) + 1.0));
          check_eq("y2", y2, $realtobits(2.0 * real'(pj) + 1.0));
          check_eq("m2", m2, $realtobits(10.0 * real'(pj) + 1.0));
        end
        pv_cnt++;
      end
      if (out_valid) begin
        oc = ov_cnt;
        if (ov_first < 0) ov_first = rel;
        ov_lastc = rel;
        if (out_last) last_cnt++;
        if (exp_n > 0) begin
          check_eq("out_i", 64'(out_i), 64'(oc / exp_n));
          check_eq("out_last", 64'(out_last), 64'((oc % exp_n) == (exp_n - 1)));
        end
        ov_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = rel;
        busy_at_done = int'(busy);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {59'd0, busy, done, rd_en, pair_valid, out_valid}, 64'd0);
    check_eq({tag, "_addr"}, {52'd0, rd_addr_i, rd_addr_j}, 64'd0);
    check_eq({tag, "_ops"}, x1 | y1 | x2 | y2 | m2, 64'd0);
    check_eq({tag, "_tag"}, {57'd0, out_i, out_last}, 64'd0);
  endtask

  // One run: nb requested bodies, en effective; optional second start at restart_at.
  task automatic run(input int nb, input int en, input int restart_at);
    int budget, rel, nn;
    clear_mon();
    exp_n = en;
    nn = en * en;
    @(negedge clk); #1;
    n_bodies  = (AW+1)'(nb);
    start     = 1'b1;
    start_cyc = cyc;
    budget    = nn + L + 40;
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      @(negedge clk); #1;
      rel = cyc - start_cyc;
      if (rel == restart_at) begin
        start    = 1'b1;
        n_bodies = (AW+1)'(2);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (5) @(negedge clk);
    #1;
    check_eq("done_cnt", 64'(done_cnt), 64'd1);
    check_eq("done_cyc", 64'(done_cyc), 64'((en == 0) ? 1 : nn + 3 + L));
    check_eq("rd_cnt", 64'(rd_cnt), 64'(nn));
    check_eq("pv_cnt", 64'(pv_cnt), 64'(nn));
    check_eq("ov_cnt", 64'(ov_cnt), 64'(nn));
    check_eq("busy_cnt", 64'(busy_cnt), 64'((en == 0) ? 0 : nn + 2 + L));
    check_eq("busy_at_done", 64'(busy_at_done), 64'd0);
    if (en > 0) begin
      check_eq("pv_first", 64'(pv_first), 64'd3);
      check_eq("ov_first", 64'(ov_first), 64'(3 + L));
      check_eq("ov_lastc", 64'(ov_lastc), 64'(nn + 2 + L));
      check_eq("last_cnt", 64'(last_cnt), 64'(en));
      check_eq("max_addr", 64'(max_addr), 64'(en - 1));
    end else begin
      check_eq("n0_firsts", 64'(pv_first + ov_first), -64'sd2);
    end
  endtask

  initial begin
    int rel;
    for (int k = 0; k < 64; k++) begin
      ram_x[k] = $realtobits(real'(k) + 1.0);
      ram_y[k] = $realtobits(2.0 * real'(k) + 1.0);
      ram_m[k] = $realtobits(10.0 * real'(k) + 1.0);
    end
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    run(1, 1, -1);
    run(3, 3, -1);
    run(0, 0, -1);
    run(4, 4, 50);

    // Reset at cycle 10 of an N=4 run.
    clear_mon();
    exp_n = 4;
    @(negedge clk); #1;
    n_bodies  = (AW+1)'(4);
    start     = 1'b1;
    start_cyc = cyc;
    rel = 0;
    for (int k = 0; k < 20 && rel < 10; k++) begin
      @(negedge clk); #1;
      start = 1'b0;
      rel = cyc - start_cyc;
    end
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
    exp_n = 0;
    repeat (200) @(negedge clk);
    #1;
    check_eq("post_rst_ov", 64'(ov_cnt), 64'd0);
    check_eq("post_rst_rd", 64'(rd_cnt + pv_cnt + done_cnt), 64'd0);
    run(2, 2, -1);

    run(100, 64, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
